// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial BCD adder/subtractor with start/done handshake
//
// Adds or subtracts two packed-BCD operands one decimal digit per clock,
// least-significant digit first, through a single shared digit adder.
// Subtraction is done as A + ninescomp(B) + 1, giving the ten's complement
// result; cout=1 then means no borrow (A >= B).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only in IDLE
//   sub      0 = A+B, 1 = A-B, sampled with start
//   a, b     packed BCD operands, digit 0 in bits [3:0]
//   busy     high while digits are being processed
//   done     one-cycle pulse when sum/cout/invalid are valid
//   sum      packed BCD result
//   cout     add: decimal carry out; sub: 1 = no borrow
//   invalid  an operand digit was greater than 9 at the accepted start
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;

  logic            in_bad;
  logic [W-1:0]    b_nines;
  logic [3:0]      a_dig, b_dig;
  logic [4:0]      t;
  logic [3:0]      dsum;
  logic            dcarry;

  // Operand screening and nines complement, evaluated on the raw inputs
  // so they are ready when start is accepted.
  always_comb begin
    in_bad  = 1'b0;
    b_nines = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
      b_nines[4*i +: 4] = 4'd9 - b[4*i +: 4];
    end
  end

  // Select the current digit pair from the latched operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Shared digit adder with decimal correction: a binary digit sum above 9
  // is pushed past 15 by adding 6, which leaves the BCD digit in the low nibble.
  always_comb begin
    t      = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    dcarry = (t > 5'd9);
    dsum   = dcarry ? (t[3:0] + 4'd6) : t[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = in_bad ? S_DONE : S_RUN;
      S_RUN:   if (idx_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? b_nines : b;
            // Carry-in of 1 turns the nines complement into a ten's complement.
            carry_q <= sub;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= in_bad;
          end
        end
        S_RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) sum[4*i +: 4] <= dsum;
          end
          carry_q <= dcarry;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST) cout <= dcarry;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised, digit-serial BCD adder/subtractor, successor to the two-digit combinational BCD adder. Adds or subtracts two DIGITS-wide packed BCD operands one decimal digit per clock, least-significant digit first, through a single shared digit-adder stage. It sits behind a start/done handshake so wide decimal operands can be processed with one digit adder's worth of logic.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode, sampled with start: 0 = A+B, 1 = A−B.
- a  input  4*DIGITS  operand A, packed BCD; digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  4*DIGITS  result, packed BCD.
- cout  output  1  add: decimal carry out; sub: 1 = A≥B (no borrow).
- invalid  output  1  an input digit was >9 at the accepted start.

## Operation
- One clock, clk; reset_n is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch a and b' into operand registers, where b' = b for add and the per-digit nines complement (9 − digit) of b for sub. Set the carry register to sub, digit index to 0, and clear sum.
  - If any digit of a or b is >9, go to DONE with invalid=1, sum=0, cout=0.
  - Otherwise clear invalid and go to RUN.
- RUN, each cycle, for digit i = index:
  - t = a_i + b'_i + carry (5-bit).
  - If t>9, the sum digit is (t+6)[3:0] and carry becomes 1; else the sum digit is t[3:0] and carry becomes 0.
  - Write the sum digit to sum[4i+3:4i] and increment index.
  - After the digit DIGITS−1, go to DONE with cout = the final carry.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Subtraction result is the ten's complement of A−B modulo 10^DIGITS. When cout=0, the true result is −(10^DIGITS − sum).
- sum, cout and invalid hold their values from DONE until the next accepted start; they do not change outside RUN/DONE.
- start while in RUN or DONE is ignored and is not queued. start held high in IDLE after DONE begins a new operation.
- Index counter width is clog2(DIGITS), minimum 1 bit. For DIGITS=1, RUN lasts one cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, invalid=0; internal carry and index are 0.
- Reset asserted mid-operation aborts it immediately and asynchronously; the partial result is discarded.
- Count edge E0 as the clock edge at which start is sampled high in IDLE.
- busy is high after E0 through edge E_DIGITS, for exactly DIGITS cycles.
- Sum digit i is updated at edge E(i+1).
- done is high for one cycle after edge E_DIGITS. Latency from the start edge to done is DIGITS+1 cycles; back-to-back throughput is one result per DIGITS+2 cycles.
- Invalid path: done pulses in the cycle after E0, and busy never rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add with DIGITS=4: a=1234, b=8766, sub=0 -> sum=0000, cout=1, done in the 5th cycle after the start edge, busy high for 4 cycles.
- Add with per-digit carry chain: a=9999, b=0001 -> sum=0000, cout=1. Also a=0456, b=0123 -> sum=0579, cout=0.
- Subtract: a=0500, b=0123, sub=1 -> sum=0377, cout=1. Also a=0123, b=0500 -> sum=9623, cout=0. Also a=b=4321 -> sum=0000, cout=1.
- Invalid input: a=12A4 -> invalid=1, sum=0000, cout=0, done one cycle after the start edge, busy stays 0. The next valid start clears invalid.
- start pulsed during RUN -> ignored, result unchanged. start held high continuously -> operations repeat every 6 cycles with a correct result each time.
- reset_n pulsed low during RUN digit 2 -> all outputs 0 immediately, state IDLE. A subsequent start gives correct results. Repeat the add scenario with DIGITS=1: a=7, b=5 -> sum=2, cout=1, done 2 cycles after the start edge.
